// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int unsigned MIN_DATA_LEN = 5;

  // True when the parity field selects a parity bit in the frame.
  function automatic logic parity_enabled(parity_e p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity over the lowest len_i bits of data_i.
module uart_parity_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_MAX = 9,
  parameter int unsigned LEN_W          = $clog2(DATA_WIDTH_MAX + 1)
) (
  input  logic [DATA_WIDTH_MAX-1:0] data_i,
  input  logic [LEN_W-1:0]          len_i,
  input  parity_e                   par_type_i,
  output logic                      par_en_o,
  output logic                      par_bit_o
);

  logic xor_acc;

  // XOR of the data bits that fall inside the effective length.
  always_comb begin
    xor_acc = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH_MAX; i++) begin
      if (i < 32'(len_i)) begin
        xor_acc = xor_acc ^ data_i[i];
      end
    end
  end

  // Select the parity bit for the requested mode; 0 when parity is off.
  always_comb begin
    par_en_o  = parity_enabled(par_type_i);
    par_bit_o = 1'b0;
    case (par_type_i)
      PAR_ODD:  par_bit_o = ~xor_acc;
      PAR_EVEN: par_bit_o = xor_acc;
      default:  par_bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_piso_gen.sv
// UART transmit serializer: one-word holding register feeding a
// start/data/parity/stop shifter advanced by BaudTick.
module uart_tx_piso_gen
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_MAX = 9,
  parameter int unsigned LEN_W          = $clog2(DATA_WIDTH_MAX + 1)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      BaudTick,
  input  logic [DATA_WIDTH_MAX-1:0] DataIn,
  input  logic [LEN_W-1:0]          DataLength,
  input  logic [1:0]                ParityType,
  input  logic                      StopBits,
  input  logic                      Send,
  output logic                      Ready,
  output logic                      DataOut,
  output logic                      ParallParOut,
  output logic                      ActiveFlag,
  output logic                      DoneFlag
);

  // Holding register
  logic                      hold_valid_q;
  logic [DATA_WIDTH_MAX-1:0] hold_data_q;
  logic [LEN_W-1:0]          hold_len_q;
  parity_e                   hold_par_q;
  logic                      hold_stop2_q;
  logic [LEN_W-1:0]          hold_len_d;

  // Shifter / FSM
  tx_state_e                 state_q;
  logic [DATA_WIDTH_MAX-1:0] shift_q;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          bit_cnt_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      stop2_q;
  logic                      stop_cnt_q;
  logic                      dout_q;
  logic                      active_q;
  logic                      done_q;
  logic                      ppar_q;

  logic par_en_d;
  logic par_bit_d;
  logic accept;
  logic stop_last;
  logic xfer;

  assign Ready        = ~hold_valid_q;
  assign DataOut      = dout_q;
  assign ParallParOut = ppar_q;
  assign ActiveFlag   = active_q;
  assign DoneFlag     = done_q;

  assign accept    = Send && ~hold_valid_q;
  assign stop_last = ~stop2_q || stop_cnt_q;
  // Hold moves into the shifter from IDLE or straight out of the last stop bit.
  assign xfer      = BaudTick && hold_valid_q &&
                     ((state_q == IDLE) || ((state_q == STOP) && stop_last));

  // Clamp the requested length into MIN_DATA_LEN..DATA_WIDTH_MAX.
  always_comb begin
    hold_len_d = DataLength;
    if (DataLength < LEN_W'(MIN_DATA_LEN)) begin
      hold_len_d = LEN_W'(MIN_DATA_LEN);
    end else if (DataLength > LEN_W'(DATA_WIDTH_MAX)) begin
      hold_len_d = LEN_W'(DATA_WIDTH_MAX);
    end
  end

  uart_parity_gen #(
    .DATA_WIDTH_MAX(DATA_WIDTH_MAX),
    .LEN_W         (LEN_W)
  ) u_parity (
    .data_i    (hold_data_q),
    .len_i     (hold_len_q),
    .par_type_i(hold_par_q),
    .par_en_o  (par_en_d),
    .par_bit_o (par_bit_d)
  );

  // Holding register: fill on accept, empty on transfer to the shifter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
      hold_par_q   <= PAR_NONE;
      hold_stop2_q <= 1'b0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= DataIn;
      hold_len_q   <= hold_len_d;
      hold_par_q   <= parity_e'(ParityType);
      hold_stop2_q <= StopBits;
    end else if (xfer) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Frame FSM with registered line, parity, active and done outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      len_q      <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      dout_q     <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      ppar_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (BaudTick) begin
        if ((state_q == STOP) && stop_last) begin
          done_q <= 1'b1;
        end
        // A transfer always starts a fresh frame, whether from IDLE or STOP.
        if (xfer) begin
          state_q    <= START;
          shift_q    <= hold_data_q;
          len_q      <= hold_len_q;
          bit_cnt_q  <= '0;
          par_en_q   <= par_en_d;
          par_bit_q  <= par_bit_d;
          stop2_q    <= hold_stop2_q;
          stop_cnt_q <= 1'b0;
          dout_q     <= 1'b0;
          active_q   <= 1'b1;
          ppar_q     <= par_bit_d;
        end else begin
          case (state_q)
            IDLE: begin
              dout_q <= 1'b1;
            end
            START: begin
              state_q   <= DATA;
              dout_q    <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= '0;
            end
            DATA: begin
              if (bit_cnt_q == len_q - LEN_W'(1)) begin
                stop_cnt_q <= 1'b0;
                if (par_en_q) begin
                  state_q <= PARITY;
                  dout_q  <= par_bit_q;
                end else begin
                  state_q <= STOP;
                  dout_q  <= 1'b1;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                dout_q    <= shift_q[0];
                shift_q   <= shift_q >> 1;
              end
            end
            PARITY: begin
              state_q    <= STOP;
              dout_q     <= 1'b1;
              stop_cnt_q <= 1'b0;
            end
            STOP: begin
              if (!stop_last) begin
                stop_cnt_q <= 1'b1;
              end else begin
                state_q  <= IDLE;
                dout_q   <= 1'b1;
                active_q <= 1'b0;
                ppar_q   <= 1'b0;
              end
            end
            default: begin
              state_q  <= IDLE;
              dout_q   <= 1'b1;
              active_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_piso_gen.sv
// Scoreboard bench for uart_tx_piso_gen: frames expected from a bit-list
// model are queued at accept and compared by a line monitor on DoneFlag.
module tb_uart_tx_piso_gen;

  localparam int DW = 9;
  localparam int LW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          BaudTick;
  logic [DW-1:0] DataIn;
  logic [LW-1:0] DataLength;
  logic [1:0]    ParityType;
  logic          StopBits;
  logic          Send;
  logic          Ready;
  logic          DataOut;
  logic          ParallParOut;
  logic          ActiveFlag;
  logic          DoneFlag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          nbits;
    logic [19:0] bits;   // bits[k] = k-th bit period on the line
    logic        par;
  } frame_t;

  frame_t exp_q[$];

  uart_tx_piso_gen #(
    .DATA_WIDTH_MAX(DW),
    .LEN_W         (LW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .BaudTick    (BaudTick),
    .DataIn      (DataIn),
    .DataLength  (DataLength),
    .ParityType  (ParityType),
    .StopBits    (StopBits),
    .Send        (Send),
    .Ready       (Ready),
    .DataOut     (DataOut),
    .ParallParOut(ParallParOut),
    .ActiveFlag  (ActiveFlag),
    .DoneFlag    (DoneFlag)
  );

  always #5 Clock = ~Clock;

  // Reference: list of line levels for one frame.
  function automatic frame_t model(logic [DW-1:0] d, int len, int pt, bit s2);
    frame_t f;
    int eff;
    int ones;
    eff = (len < 5) ? 5 : ((len > DW) ? DW : len);
    ones = 0;
    f.bits = '0;
    f.bits[0] = 1'b0;
    f.nbits = 1;
    f.par = 1'b0;
    for (int i = 0; i < eff; i++) begin
      f.bits[f.nbits] = d[i];
      if (d[i]) ones++;
      f.nbits++;
    end
    if (pt == 1) f.par = (ones % 2 == 0);
    if (pt == 2) f.par = (ones % 2 == 1);
    if (pt == 1 || pt == 2) begin
      f.bits[f.nbits] = f.par;
      f.nbits++;
    end
    f.bits[f.nbits] = 1'b1;
    f.nbits++;
    if (s2) begin
      f.bits[f.nbits] = 1'b1;
      f.nbits++;
    end
    return f;
  endfunction

  // Baud tick source: one-cycle pulses with random 1..4 cycle gaps.
  initial begin
    BaudTick = 1'b0;
    forever begin
      repeat ($urandom_range(1, 4)) @(posedge Clock);
      #2 BaudTick = 1'b1;
      @(posedge Clock);
      #2 BaudTick = 1'b0;
    end
  end

  // Monitor: collect one line sample per tick while active; check on DoneFlag.
  logic [19:0] cur_bits;
  int          cur_n;
  logic        cur_par;
  frame_t      mon_f;
  initial begin
    cur_bits = '0;
    cur_n    = 0;
    cur_par  = 1'b0;
  end
  always @(negedge Clock) begin
    if (Reset) begin
      cur_bits = '0;
      cur_n    = 0;
    end else begin
      if (DoneFlag) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected got %0d bits %b with no frame queued", cur_n, cur_bits);
        end else begin
          mon_f = exp_q.pop_front();
          if (cur_n != mon_f.nbits || cur_bits != mon_f.bits) begin
            errors++;
            $display("FAIL frame_bits got n=%0d %b expected n=%0d %b",
                     cur_n, cur_bits, mon_f.nbits, mon_f.bits);
          end
          checks++;
          if (cur_par !== mon_f.par) begin
            errors++;
            $display("FAIL parallparout got %0b expected %0b", cur_par, mon_f.par);
          end
        end
        cur_bits = '0;
        cur_n    = 0;
      end
      if (BaudTick && ActiveFlag) begin
        if (cur_n == 0) cur_par = ParallParOut;
        if (cur_n < 20) cur_bits[cur_n] = DataOut;
        cur_n++;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait for Ready, present one word for one cycle, queue its expected frame.
  task automatic send(input logic [DW-1:0] d, input int len, input int pt, input bit s2);
    int t;
    t = 0;
    @(negedge Clock);
    while (!Ready && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    if (!Ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready got %0b expected 1", Ready);
      return;
    end
    DataIn     = d;
    DataLength = len[LW-1:0];
    ParityType = pt[1:0];
    StopBits   = s2;
    Send       = 1'b1;
    exp_q.push_back(model(d, len, pt, s2));
    @(negedge Clock);
    Send       = 1'b0;
    DataIn     = DW'($urandom);
    DataLength = LW'($urandom);
    ParityType = 2'($urandom);
    StopBits   = 1'($urandom);
    chk("ready_after_accept", Ready, 1'b0);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || ActiveFlag) && t < 5000) begin
      @(negedge Clock);
      t++;
    end
    checks++;
    if (exp_q.size() != 0 || ActiveFlag) begin
      errors++;
      $display("FAIL idle_timeout pending got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    int t;
    seen = 0;
    t = 0;
    while (seen < n && t < 1000) begin
      @(negedge Clock);
      if (BaudTick) seen++;
      t++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout got %0d expected %0d", seen, n);
    end
  endtask

  task automatic wait_active();
    int t;
    t = 0;
    while (!ActiveFlag && t < 1000) begin
      @(negedge Clock);
      t++;
    end
    if (!ActiveFlag) begin
      checks++;
      errors++;
      $display("FAIL active_timeout got 0 expected 1");
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ntick;
    int nd;
    int gap;
    int t;
    Reset      = 1'b1;
    Send       = 1'b0;
    DataIn     = '0;
    DataLength = '0;
    ParityType = '0;
    StopBits   = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_dataout", DataOut, 1'b1);
    chk("rst_ready", Ready, 1'b1);
    chk("rst_active", ActiveFlag, 1'b0);
    chk("rst_done", DoneFlag, 1'b0);
    chk("rst_par", ParallParOut, 1'b0);
    Reset = 1'b0;

    // 8N1 and start latency: first tick strictly after accept starts the frame.
    send(9'h04A, 8, 0, 0);
    ntick = 0;
    t = 0;
    while (!ActiveFlag && t < 1000) begin
      if (BaudTick) ntick++;
      @(negedge Clock);
      t++;
    end
    chk_int("start_latency_ticks", ntick, 1);
    wait_idle();

    // Odd / even parity, 7-bit even with 2 stop bits and ignored bit 8.
    send(9'h04A, 8, 1, 0);
    wait_idle();
    send(9'h04A, 8, 2, 0);
    wait_idle();
    send(9'h14A, 7, 2, 1);
    wait_idle();

    // Length clamps.
    send(9'h1F3, 3, 1, 0);
    wait_idle();
    send(9'h1A5, 15, 2, 1);
    wait_idle();
    send(9'h0C3, 0, 0, 1);
    wait_idle();

    // Back-to-back: second word waits in hold; a third Send is ignored.
    send(9'h055, 8, 0, 0);
    wait_active();
    wait_ticks(3);
    send(9'h0AA, 8, 2, 1);
    @(negedge Clock);
    DataIn = 9'h1FF;
    Send   = 1'b1;
    @(negedge Clock);
    Send   = 1'b0;
    chk("ready_while_held", Ready, 1'b0);
    nd  = 0;
    gap = 0;
    t   = 0;
    while (nd < 2 && t < 2000) begin
      @(negedge Clock);
      if (DoneFlag) nd++;
      if (nd == 1 && !ActiveFlag) gap++;
      t++;
    end
    chk_int("b2b_done_pulses", nd, 2);
    chk_int("b2b_idle_gap_cycles", gap, 0);
    wait_idle();

    // Reset in the middle of the data field (bit 4 on the line).
    send(9'h1B6, 9, 1, 0);
    wait_active();
    wait_ticks(5);
    Reset = 1'b1;
    exp_q.delete();
    @(negedge Clock);
    chk("midrst_dataout", DataOut, 1'b1);
    chk("midrst_active", ActiveFlag, 1'b0);
    chk("midrst_ready", Ready, 1'b1);
    chk("midrst_done", DoneFlag, 1'b0);
    Reset = 1'b0;
    repeat (40) @(negedge Clock);
    send(9'h12D, 9, 2, 1);
    wait_idle();

    // Random traffic, sometimes back-to-back, sometimes with idle time.
    for (int i = 0; i < 40; i++) begin
      send(DW'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 60)) @(negedge Clock);
      end
    end
    wait_idle();
    repeat (20) @(negedge Clock);
    chk_int("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
